// File: rtl/uart_pkg.sv
// uart_pkg: shared UART clock rate, divisor field widths and preset baud divisors
package uart_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_INT_W = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DIV_INT_9600 = 651;
  localparam int DIV_FRAC_9600 = 1;
  localparam int DIV_INT_115200 = 54;
  localparam int DIV_FRAC_115200 = 4;
endpackage

// File: rtl/baud_gen_frac_frac_accum.sv
// frac_accum: FRAC_W-bit fractional accumulator; ports clk_100MHz/reset_n, clear, step, frac in, carry out
module frac_accum import uart_pkg::*; #(
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc;
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) {carry, acc} <= '0;
    else if (clear) {carry, acc} <= '0;
    else if (step) {carry, acc} <= {1'b0, acc} + {1'b0, frac};
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud tick generator; ports clk_100MHz/reset_n, enable, sync_clear, div_int/div_frac/div_load in; div_pending, os_tick, bit_tick, os_phase out
module baud_gen_frac import uart_pkg::*; #(
  parameter int INT_W = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DEF_INT = DIV_INT_9600,
  parameter int DEF_FRAC = DIV_FRAC_9600
) (
  input  logic                          clk_100MHz,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          sync_clear,
  input  logic [INT_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          div_pending,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  logic [INT_W-1:0] counter, act_int, shd_int, load_int;
  logic [FRAC_W-1:0] act_frac, shd_frac;
  logic [INT_W:0] period_m1;
  logic carry_q, apply;
  always_comb begin
    period_m1 = {1'b0, act_int} + {{INT_W{1'b0}}, carry_q} - (INT_W+1)'(1);
    os_tick = enable && !sync_clear && ({1'b0, counter} == period_m1);
    bit_tick = os_tick && (os_phase == PH_LAST);
    apply = div_pending && (os_tick || !enable || sync_clear);
    load_int = div_int < INT_W'(2) ? INT_W'(2) : div_int;
  end
  frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .clear(sync_clear || apply),
    .step(os_tick),
    .frac(act_frac),
    .carry(carry_q)
  );
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      counter <= '0;
      os_phase <= '0;
    end else begin
      counter <= (sync_clear || os_tick) ? '0 : enable ? counter + INT_W'(1) : counter;
      os_phase <= sync_clear ? '0 : !os_tick ? os_phase : os_phase == PH_LAST ? '0 : os_phase + PH_W'(1);
    end
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      act_int <= INT_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      shd_int <= INT_W'(DEF_INT);
      shd_frac <= FRAC_W'(DEF_FRAC);
      div_pending <= 1'b0;
    end else begin
      if (apply) begin
        act_int <= shd_int;
        act_frac <= shd_frac;
      end
      if (div_load) begin
        shd_int <= load_int;
        shd_frac <= div_frac;
      end
      div_pending <= div_load || (div_pending && !apply);
    end
endmodule
